duc_tx_sched: RTL and testbench

- Transmit scheduler for the DUC path, running on axis_clk.
- Reads baseband words from the DUC sample RAM (one-cycle read latency) and streams them as AXI-Stream frames with tlast.
- Supports a configurable repeat count and a configurable inter-frame gap.
- Host-side command and config registers are synchronised into axis_clk upstream of this block.

---
 rtl/duc_tx_sched_pkg.sv | 21 ++
 rtl/duc_tx_skid.sv | 52 +++++
 rtl/duc_tx_sched.sv | 175 +++++++++++++++++
 tb/tb_duc_tx_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duc_tx_sched_pkg.sv
// duc_tx_sched shared types: FSM states, skid entry layout and header constants.
// Used by duc_tx_sched and duc_tx_skid.
package duc_tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        GAP,
        FIN
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    localparam logic [7:0] HDR_MAGIC  = 8'hA5;
    localparam int         SKID_DEPTH = 2;

endpackage

// File: rtl/duc_tx_skid.sv
// Two-entry fall-through skid FIFO between the sample RAM and the AXI-Stream port.
// An empty FIFO presents the incoming word in the same cycle it arrives.
module duc_tx_skid
    import duc_tx_sched_pkg::*;
(
    input  logic        axis_clk,
    input  logic        rst,
    input  logic        push,
    input  beat_t       push_beat,
    input  logic        pop_ready,
    output logic        out_valid,
    output beat_t       out_beat,
    output logic [1:0]  count
);

    beat_t mem [SKID_DEPTH];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  pop;
    logic  store;
    logic  drain;

    assign out_valid = (count != 2'd0) || push;
    assign out_beat  = (count != 2'd0) ? mem[rd_ptr] : push_beat;
    assign pop       = out_valid && pop_ready;
    assign drain     = pop && (count != 2'd0);
    // A word popped straight through an empty FIFO is never stored.
    assign store     = push && !(pop && (count == 2'd0));

    always_ff @(posedge axis_clk) begin
        if (store) begin
            mem[wr_ptr] <= push_beat;
        end
    end

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) begin
                wr_ptr <= ~wr_ptr;
            end
            if (drain) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(store) - 2'(drain);
        end
    end

endmodule

// File: rtl/duc_tx_sched.sv
// DUC transmit scheduler: streams sample-RAM frames with repeat and gap control.
// Define DUC_TX_SCHED_HDR_EN to prepend a header beat to every frame.
module duc_tx_sched
    import duc_tx_sched_pkg::*;
#(
    parameter int U_DLY = 1,
    parameter int AW    = 12,
    parameter int GAP_W = 16
) (
    input  logic             axis_clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic [AW-1:0]    cfg_base,
    input  logic [AW-1:0]    cfg_len,
    input  logic [7:0]       cfg_repeat,
    input  logic [GAP_W-1:0] cfg_gap,
    output logic             buf_rd,
    output logic [AW-1:0]    buf_raddr,
    input  logic [31:0]      buf_rdata,
    output logic             m_axis_tvalid,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       frame_cnt
);

    state_t           state;
    state_t           state_n;
    logic [AW-1:0]    base_q;
    logic [AW-1:0]    len_q;
    logic [AW-1:0]    idx;
    logic [7:0]       rep_q;
    logic [7:0]       frame_cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             abort_pend;
    logic             err_q;
    logic             rv;
    logic             rhdr;
    logic             rlast;
    logic             hdr_pend;
    logic [1:0]       occ;
    logic             iss;
    logic             last_acc;
    logic             abort_any;
    logic             restart;
    logic [31:0]      hdr_word;
    beat_t            push_beat;
    beat_t            out_beat;
    logic             unused_dly;

    // Registers update without intra-assignment delay; U_DLY is kept for port compatibility.
    assign unused_dly = (U_DLY != 0);

    assign last_acc  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign abort_any = abort_pend || cmd_abort;
    // Reads in flight count against the FIFO so an issued word always has a slot.
    assign iss = (state == STREAM) && (hdr_pend || (idx < len_q))
              && ((3'(occ) + 3'(rv)) < 3'(SKID_DEPTH));
    assign restart = (state_n == STREAM) && ((state != STREAM) || last_acc);

    assign hdr_word  = {HDR_MAGIC, frame_cnt_q, 4'h0, 12'(len_q)};
    assign push_beat = '{data: (rhdr ? hdr_word : buf_rdata), last: rlast};
    assign buf_raddr = base_q + idx;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (cmd_start && (cfg_len != '0)) state_n = LOAD;
            end
            LOAD: state_n = STREAM;
            STREAM: begin
                if (last_acc) begin
                    if (abort_any || (frame_cnt_q == rep_q)) state_n = FIN;
                    else if (gap_q == '0)                    state_n = STREAM;
                    else                                     state_n = GAP;
                end
            end
            GAP: begin
                if (abort_any)                              state_n = FIN;
                else if (gap_cnt == gap_q - GAP_W'(1))      state_n = STREAM;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        done   = (state == FIN);
        buf_rd = iss && !hdr_pend;
    end

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            idx         <= '0;
            frame_cnt_q <= '0;
            gap_cnt     <= '0;
            abort_pend  <= 1'b0;
            err_q       <= 1'b0;
            rv          <= 1'b0;
            rhdr        <= 1'b0;
            rlast       <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && cmd_start && (cfg_len == '0);
            if ((state == IDLE) && cmd_start && (cfg_len != '0)) begin
                base_q <= cfg_base;
                len_q  <= cfg_len;
                rep_q  <= cfg_repeat;
                gap_q  <= cfg_gap;
            end
            if (state == IDLE)  abort_pend <= 1'b0;
            else if (cmd_abort) abort_pend <= 1'b1;
            if (restart)                idx <= '0;
            else if (iss && !hdr_pend)  idx <= idx + AW'(1);
            if (state == LOAD) begin
                frame_cnt_q <= '0;
            end else if ((state == STREAM) && last_acc && (frame_cnt_q != 8'hFF)) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            rv      <= iss;
            rhdr    <= iss && hdr_pend;
            rlast   <= iss && !hdr_pend && (idx == len_q - AW'(1));
        end
    end

`ifdef DUC_TX_SCHED_HDR_EN
    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            hdr_pend <= 1'b0;
        end else if (restart) begin
            hdr_pend <= 1'b1;
        end else if (iss) begin
            hdr_pend <= 1'b0;
        end
    end
`else
    assign hdr_pend = 1'b0;
`endif

    duc_tx_skid u_skid (
        .axis_clk  (axis_clk),
        .rst       (rst),
        .push      (rv),
        .push_beat (push_beat),
        .pop_ready (m_axis_tready),
        .out_valid (m_axis_tvalid),
        .out_beat  (out_beat),
        .count     (occ)
    );

    assign m_axis_tdata = out_beat.data;
    assign m_axis_tlast = out_beat.last;

endmodule

// File: tb/tb_duc_tx_sched.sv
// Scoreboard bench for duc_tx_sched: directed frames, stalls, gaps, abort, reset.
// Honours DUC_TX_SCHED_HDR_EN when building expected streams.
module tb_duc_tx_sched;

    localparam int AW    = 12;
    localparam int GAP_W = 16;
`ifdef DUC_TX_SCHED_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic             axis_clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_start = 1'b0;
    logic             cmd_abort = 1'b0;
    logic [AW-1:0]    cfg_base = '0;
    logic [AW-1:0]    cfg_len = '0;
    logic [7:0]       cfg_repeat = '0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic             buf_rd;
    logic [AW-1:0]    buf_raddr;
    logic [31:0]      buf_rdata = '0;
    logic             m_axis_tvalid;
    logic [31:0]      m_axis_tdata;
    logic             m_axis_tlast;
    logic             m_axis_tready = 1'b1;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       frame_cnt;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [32:0] exp_beat [$];
    logic [AW-1:0] exp_addr [$];
    int          gaps [$];
    int          acc_beats = 0;
    int          last_cyc = 0;
    int          valid_in_gap = 0;
    bit          wait_rd = 0;
    bit          err_seen = 0;
    bit          rdy_mode = 0;
    logic [3:0]  rdy_pat = 4'b1001;
    bit          sv_valid = 0;
    logic [32:0] sv_beat = '0;

    duc_tx_sched dut (
        .axis_clk      (axis_clk),
        .rst           (rst),
        .cmd_start     (cmd_start),
        .cmd_abort     (cmd_abort),
        .cfg_base      (cfg_base),
        .cfg_len       (cfg_len),
        .cfg_repeat    (cfg_repeat),
        .cfg_gap       (cfg_gap),
        .buf_rd        (buf_rd),
        .buf_raddr     (buf_raddr),
        .buf_rdata     (buf_rdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .frame_cnt     (frame_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_val(input logic [AW-1:0] a);
        return {8'hD5, 4'h0, a, 8'h5A};
    endfunction

    always @(posedge axis_clk) begin
        if (buf_rd) buf_rdata <= ram_val(buf_raddr);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string info);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", nm, info);
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge axis_clk);
            #1;
            m_axis_tready = rdy_mode ? rdy_pat[cyc % 4] : 1'b1;
        end
    end

    // Monitor: address and beat scoreboards, stall stability, gap observation.
    always @(negedge axis_clk) begin
        if (!rst) begin
            if (buf_rd) begin
                if (exp_addr.size() == 0) fail("raddr", $sformatf("unexpected read at 0x%0h", buf_raddr));
                else check("raddr", 64'(buf_raddr), 64'(exp_addr.pop_front()));
                if (wait_rd) begin
                    gaps.push_back(cyc - last_cyc - 1);
                    wait_rd = 0;
                end
            end else if (wait_rd && m_axis_tvalid) begin
                valid_in_gap++;
            end
            if (sv_valid) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'(1));
                check("stall_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(sv_beat));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                acc_beats++;
                if (exp_beat.size() == 0) fail("beat", $sformatf("unexpected beat 0x%0h", m_axis_tdata));
                else check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_beat.pop_front()));
                if (m_axis_tlast) begin
                    last_cyc = cyc;
                    wait_rd = 1;
                end
            end
            sv_valid = m_axis_tvalid && !m_axis_tready;
            sv_beat  = {m_axis_tlast, m_axis_tdata};
            if (err) err_seen = 1;
        end else begin
            sv_valid = 0;
        end
    end

    task automatic push_exp(input logic [AW-1:0] base, input logic [AW-1:0] len, input int frames);
        for (int f = 0; f < frames; f++) begin
            if (HDR != 0) exp_beat.push_back({1'b0, 8'hA5, 8'(f), 4'h0, len});
            for (int i = 0; i < int'(len); i++) begin
                logic [AW-1:0] a;
                a = base + AW'(i);
                exp_addr.push_back(a);
                exp_beat.push_back({(i == int'(len) - 1), ram_val(a)});
            end
        end
    endtask

    task automatic run_seq(input string nm, input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic [7:0] rep, input logic [GAP_W-1:0] gap,
                           input int frames, input int abort_at);
        int start_cyc;
        int first_rd;
        int first_v;
        int done_cyc;
        bit got;
        bit aborted;
        push_exp(base, len, frames);
        gaps.delete();
        wait_rd = 0;
        acc_beats = 0;
        valid_in_gap = 0;
        err_seen = 0;
        cfg_base = base;
        cfg_len = len;
        cfg_repeat = rep;
        cfg_gap = gap;
        cmd_start = 1'b1;
        start_cyc = cyc;
        tick();
        cmd_start = 1'b0;
        first_rd = -1;
        first_v = -1;
        done_cyc = 0;
        got = 0;
        aborted = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge axis_clk);
            if (first_rd < 0 && buf_rd) first_rd = cyc;
            if (first_v < 0 && m_axis_tvalid) first_v = cyc;
            if (done) begin
                got = 1;
                done_cyc = cyc;
                check({nm, "_frame_cnt"}, 64'(frame_cnt), 64'(frames));
                check({nm, "_busy_fin"}, 64'(busy), 64'(1));
            end else if (abort_at >= 0 && !aborted && acc_beats >= abort_at) begin
                aborted = 1;
                @(posedge axis_clk);
                #1 cmd_abort = 1'b1;
                tick();
                cmd_abort = 1'b0;
            end
        end
        if (!got) begin
            fail({nm, "_done"}, "timeout waiting for done");
        end else begin
            check({nm, "_done_lat"}, 64'(done_cyc - last_cyc), 64'(1));
            check({nm, "_rd_lat"}, 64'(first_rd - start_cyc), 64'(2 + HDR));
            check({nm, "_valid_lat"}, 64'(first_v - start_cyc), 64'(3));
            @(negedge axis_clk);
            check({nm, "_done_pulse"}, 64'(done), 64'(0));
            check({nm, "_idle"}, 64'(busy), 64'(0));
            check({nm, "_beats_left"}, 64'(exp_beat.size()), 64'(0));
            check({nm, "_reads_left"}, 64'(exp_addr.size()), 64'(0));
            check({nm, "_no_err"}, 64'(err_seen), 64'(0));
        end
        exp_beat.delete();
        exp_addr.delete();
        tick();
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge axis_clk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("rst_buf_rd", 64'(buf_rd), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        run_seq("basic", 12'd0, 12'd4, 8'd0, 16'd0, 1, -1);
        run_seq("wrap", 12'd4094, 12'd4, 8'd0, 16'd0, 1, -1);

        run_seq("gap", 12'h100, 12'd3, 8'd2, 16'd5, 3, -1);
        check("gap_count", 64'(gaps.size()), 64'(2));
        foreach (gaps[i]) check($sformatf("gap_len%0d", i), 64'(gaps[i]), 64'(5 + HDR));
        check("gap_no_valid", 64'(valid_in_gap), 64'(0));

        rdy_mode = 1;
        run_seq("stall", 12'h200, 12'd8, 8'd0, 16'd0, 1, -1);
        rdy_mode = 0;

        run_seq("b2b", 12'h300, 12'd5, 8'd2, 16'd0, 3, -1);
        check("b2b_count", 64'(gaps.size()), 64'(2));
        foreach (gaps[i]) check($sformatf("b2b_gap%0d", i), 64'(gaps[i]), 64'(HDR));

        run_seq("abort", 12'h400, 12'd6, 8'd2, 16'd3, 1, 2);

        cfg_len = '0;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        @(negedge axis_clk);
        check("len0_err", 64'(err), 64'(1));
        check("len0_busy", 64'(busy), 64'(0));
        @(negedge axis_clk);
        check("len0_err_pulse", 64'(err), 64'(0));
        check("len0_busy2", 64'(busy), 64'(0));
        tick();

        run_seq("hdr", 12'h010, 12'd2, 8'd1, 16'd0, 2, -1);

        push_exp(12'h500, 12'd8, 4);
        acc_beats = 0;
        cfg_base = 12'h500;
        cfg_len = 12'd8;
        cfg_repeat = 8'd3;
        cfg_gap = '0;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        seen = 0;
        for (int k = 0; k < 500 && seen == 0; k++) begin
            @(negedge axis_clk);
            if (acc_beats >= 3) seen = 1;
        end
        if (seen == 0) fail("midrst_progress", "stream never started");
        tick();
        rst = 1'b1;
        @(negedge axis_clk);
        check("midrst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("midrst_buf_rd", 64'(buf_rd), 64'(0));
        tick();
        exp_beat.delete();
        exp_addr.delete();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge axis_clk);
            if (done || m_axis_tvalid) seen++;
        end
        check("midrst_quiet", 64'(seen), 64'(0));
        tick();

        run_seq("recover", 12'h000, 12'd4, 8'd0, 16'd0, 1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
